// File: rtl/trace_unpack.sv
// Reassembles narrow bus words (LS word first) into full-width trace records,
// with framing-error detection, resync on the last flag and a 2-entry output buffer.
module trace_unpack #(
  parameter int unsigned width  = 48,
  parameter int unsigned owidth = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_enq__ENA,
  input  logic [owidth-1:0] in_enq_v,
  input  logic              in_enq_last,
  output logic              in_enq__RDY,
  output logic [width-1:0]  out_first,
  output logic              out_first__RDY,
  input  logic              out_deq__ENA,
  output logic              out_deq__RDY,
  input  logic              clear__ENA,
  output logic              clear__RDY,
  output logic [7:0]        err_count
);

  localparam int unsigned N  = (width + owidth - 1) / owidth;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = N * owidth;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {ASSEMBLE, DROP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic            store, push, err_inc;
  logic            at_last, accept, pop;
  logic [AW-1:0]   acc, acc_full;
  logic [width-1:0] entry [2];
  logic            rd, wr;
  logic [1:0]      count;

  assign at_last = (idx == LAST_IDX);
  // Ready depends only on registered state, never on same-cycle deq
  assign in_enq__RDY    = !(state == ASSEMBLE && at_last && count == 2'd2);
  assign accept         = in_enq__ENA && in_enq__RDY && !clear__ENA;
  assign pop            = out_deq__ENA && (count != 2'd0) && !clear__ENA;
  assign out_first      = entry[rd];
  assign out_first__RDY = (count != 2'd0);
  assign out_deq__RDY   = out_first__RDY;
  assign clear__RDY     = 1'b1;

  // Final word fills the top slot; bits beyond width fall away on truncation
  always_comb begin
    acc_full = acc;
    acc_full[(N-1)*owidth +: owidth] = in_enq_v;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ASSEMBLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    store   = 1'b0;
    push    = 1'b0;
    err_inc = 1'b0;
    if (clear__ENA) begin
      state_n = ASSEMBLE;
      idx_n   = '0;
    end else if (accept) begin
      case (state)
        ASSEMBLE: begin
          if (!at_last) begin
            if (in_enq_last) begin
              idx_n   = '0;
              err_inc = 1'b1;
            end else begin
              store = 1'b1;
              idx_n = idx + IW'(1);
            end
          end else if (in_enq_last) begin
            push  = 1'b1;
            idx_n = '0;
          end else begin
            err_inc = 1'b1;
            idx_n   = '0;
            state_n = DROP;
          end
        end
        DROP: begin
          if (in_enq_last) begin
            state_n = ASSEMBLE;
            idx_n   = '0;
          end
        end
        default: begin
          state_n = ASSEMBLE;
          idx_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc       <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      count     <= 2'd0;
      err_count <= 8'd0;
    end else if (clear__ENA) begin
      acc       <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      count     <= 2'd0;
      err_count <= 8'd0;
    end else begin
      if (store)
        acc[idx*owidth +: owidth] <= in_enq_v;
      if (push)
        wr <= ~wr;
      if (pop)
        rd <= ~rd;
      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;
      if (err_inc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  // Buffer storage; cleared only by reset so out_first reads 0 out of reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      entry[0] <= '0;
      entry[1] <= '0;
    end else if (push && !clear__ENA) begin
      entry[wr] <= acc_full[width-1:0];
    end
  end

endmodule

// File: tb/tb_trace_unpack.sv
// Directed bench for trace_unpack: a queue-based record model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_trace_unpack;

  localparam int unsigned W  = 48;
  localparam int unsigned OW = 32;
  localparam int unsigned N  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_ena, enq_last, deq_ena, clr_ena;
  logic [OW-1:0] enq_v;
  logic          in_rdy, out_rdy, deq_rdy, clear_rdy;
  logic [W-1:0]  out_first;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  trace_unpack #(.width(W), .owidth(OW)) dut (
    .CLK(clk), .RST(rst),
    .in_enq__ENA(enq_ena), .in_enq_v(enq_v), .in_enq_last(enq_last),
    .in_enq__RDY(in_rdy),
    .out_first(out_first), .out_first__RDY(out_rdy),
    .out_deq__ENA(deq_ena), .out_deq__RDY(deq_rdy),
    .clear__ENA(clr_ena), .clear__RDY(clear_rdy),
    .err_count(err_count)
  );

  // Model: words of the record in progress, drop flag, buffered records, errors
  logic [OW-1:0] m_words[$];
  bit            m_drop;
  logic [W-1:0]  m_q[$];
  int            m_err;
  int            errors = 0;
  int            checks = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit m_rdy();
    return !(!m_drop && m_words.size() == N - 1 && m_q.size() == 2);
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_q.delete();
    m_drop = 1'b0;
    m_err  = 0;
  endtask

  task automatic compare();
    check("in_rdy", 64'(in_rdy), 64'(m_rdy()));
    check("out_rdy", 64'(out_rdy), 64'(m_q.size() != 0));
    check("deq_rdy", 64'(deq_rdy), 64'(m_q.size() != 0));
    check("clear_rdy", 64'(clear_rdy), 64'd1);
    check("err_count", 64'(err_count), 64'(m_err));
    if (m_q.size() != 0) check("out_first", 64'(out_first), 64'(m_q[0]));
  endtask

  task automatic model_step(bit enq, logic [OW-1:0] v, bit last, bit deq, bit clr);
    logic [127:0] r;
    bit rdy;
    rdy = m_rdy();
    if (clr) begin
      model_reset();
      return;
    end
    if (deq && m_q.size() != 0) void'(m_q.pop_front());
    if (!(enq && rdy)) return;
    if (m_drop) begin
      if (last) m_drop = 1'b0;
    end else if (m_words.size() < N - 1) begin
      if (last) begin
        m_words.delete();
        if (m_err < 255) m_err++;
      end else begin
        m_words.push_back(v);
      end
    end else if (last) begin
      r = '0;
      foreach (m_words[k]) r |= 128'(m_words[k]) << (k * OW);
      r |= 128'(v) << ((N - 1) * OW);
      m_q.push_back(r[W-1:0]);
      m_words.delete();
    end else begin
      m_words.delete();
      if (m_err < 255) m_err++;
      m_drop = 1'b1;
    end
  endtask

  // One clock: check current outputs, drive inputs, advance the model
  task automatic step(bit enq, logic [OW-1:0] v, bit last, bit deq, bit clr);
    compare();
    enq_ena  = enq;
    enq_v    = v;
    enq_last = last;
    deq_ena  = deq;
    clr_ena  = clr;
    model_step(enq, v, last, deq, clr);
    @(posedge clk);
    #1;
    enq_ena = 1'b0;
    deq_ena = 1'b0;
    clr_ena = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic deq();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic clr();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic word(logic [OW-1:0] v, bit last);
    step(1'b1, v, last, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    enq_ena = 1'b0; enq_v = '0; enq_last = 1'b0; deq_ena = 1'b0; clr_ena = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_first", 64'(out_first), 64'h0);
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
    check("rst_out_rdy", 64'(out_rdy), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic record and deq
    word(32'h89ABCDEF, 1'b0);
    word(32'h00004567, 1'b1);
    check("lit_basic", 64'(out_first), 64'h456789ABCDEF);
    check("lit_basic_rdy", 64'(out_rdy), 64'd1);
    deq();
    check("lit_basic_empty", 64'(out_rdy), 64'd0);

    // Upper bits of final word ignored
    word(32'h89ABCDEF, 1'b0);
    word(32'hFFFF4567, 1'b1);
    check("lit_trunc", 64'(out_first), 64'h456789ABCDEF);
    deq();

    // Backpressure on the third record's final word
    clr();
    word(32'h11110001, 1'b0); word(32'h0000AAA1, 1'b1);
    word(32'h11110002, 1'b0); word(32'h0000AAA2, 1'b1);
    word(32'h11110003, 1'b0);
    check("lit_bp_rdy_low", 64'(in_rdy), 64'd0);
    word(32'h0000AAA3, 1'b1);
    deq();
    check("lit_bp_rdy_high", 64'(in_rdy), 64'd1);
    check("lit_bp_head2", 64'(out_first), 64'hAAA211110002);
    word(32'h0000AAA3, 1'b1);
    deq();
    check("lit_bp_head3", 64'(out_first), 64'hAAA311110003);
    deq();
    check("lit_bp_empty", 64'(out_rdy), 64'd0);

    // Short record then valid record; also push and deq in the same cycle
    clr();
    word(32'h11111111, 1'b1);
    word(32'h22222222, 1'b0);
    word(32'h00003333, 1'b1);
    check("lit_short_err", 64'(err_count), 64'd1);
    check("lit_short_rec", 64'(out_first), 64'h333322222222);
    word(32'h44444444, 1'b0);
    step(1'b1, 32'h00005555, 1'b1, 1'b1, 1'b0);
    check("lit_simul_rec", 64'(out_first), 64'h555544444444);
    deq();

    // Long record dropped until last, then valid record
    clr();
    word(32'hA, 1'b0); word(32'hB, 1'b0); word(32'hC, 1'b0); word(32'hD, 1'b1);
    check("lit_long_none", 64'(out_rdy), 64'd0);
    word(32'h55555555, 1'b0);
    word(32'h00006666, 1'b1);
    check("lit_long_err", 64'(err_count), 64'd1);
    check("lit_long_rec", 64'(out_first), 64'h666655555555);
    deq();
    deq(); // illegal deq while empty
    idle();

    // Clear beats a same-cycle enq that would complete a record
    clr();
    word(32'h1, 1'b1); word(32'h2, 1'b1); word(32'h3, 1'b1);
    word(32'h77777777, 1'b0); word(32'h00008888, 1'b1);
    word(32'h99999999, 1'b0);
    check("lit_pre_clear_err", 64'(err_count), 64'd3);
    step(1'b1, 32'h0000AAAA, 1'b1, 1'b0, 1'b1);
    check("lit_clear_rdy", 64'(out_rdy), 64'd0);
    check("lit_clear_err", 64'(err_count), 64'd0);
    word(32'hBBBBBBBB, 1'b0);
    word(32'h0000CCCC, 1'b1);
    check("lit_clear_idx", 64'(out_first), 64'hCCCCBBBBBBBB);
    deq();

    // Reset mid-record loses the partial record
    word(32'hDEADBEEF, 1'b0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    word(32'h12345678, 1'b0);
    word(32'h00009ABC, 1'b1);
    check("lit_rst_mid", 64'(out_first), 64'h9ABC12345678);
    check("lit_rst_mid_err", 64'(err_count), 64'd0);
    deq();

    // Error counter saturation
    clr();
    for (int i = 0; i < 300; i++) word(32'(i), 1'b1);
    idle();
    check("lit_sat", 64'(err_count), 64'd255);

    compare();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
